// File: rtl/sprite_arb_pkg.sv
// Shared types and helpers for the sprite ROM arbiter: id width helper and pipeline stage struct.
package sprite_arb_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int ID_W_MAX   = 3;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Ids are stored at the widest supported width (8 requesters) and narrowed at the output.
  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } pipe_stage_t;

  localparam pipe_stage_t PIPE_IDLE = '{valid: 1'b0, id: '0};

endpackage

// File: rtl/sprite_rom_arbiter_rr.sv
// Masked one-hot round-robin picker: lowest request at or above ptr wins, else lowest overall.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked  = req & mask;
    pick    = (masked != '0) ? masked : req;
    gnt     = pick & (~pick + N'(1));
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = IW'(i);
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one registered-address sprite ROM; 3-cycle tagged read pipeline.
// Optional grant locking is enabled by defining SPRITE_ARB_LOCK_EN.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ROW_W    = 5,
  parameter int COL_W    = 5,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_LOCK = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         arb_en,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ROW_W-1:0]     req_row,
  input  logic [NUM_REQ*COL_W-1:0]     req_col,
  input  logic [NUM_REQ-1:0]           req_lock,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [ROW_W-1:0]             rom_row,
  output logic [COL_W-1:0]             rom_col,
  input  logic [DATA_W-1:0]            rom_data,
  output logic                         rd_valid,
  output logic [id_width(NUM_REQ)-1:0] rd_id,
  output logic [DATA_W-1:0]            rd_data
);

  localparam int IW = id_width(NUM_REQ);

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      ptr_adv;
  logic [NUM_REQ-1:0] pick;
  logic               granted;
  pipe_stage_t        s1;
  pipe_stage_t        s2;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (req),
    .ptr     (ptr),
    .gnt     (pick),
    .gnt_idx (pick_idx)
  );

  // A requester holds req and its address until it sees gnt in the same cycle; gnt means the
  // access was accepted on this clock edge, and req may stay high with a new address next cycle.
  assign gnt     = arb_en ? pick : '0;
  assign granted = |gnt;
  assign ptr_adv = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_row  <= '0;
      rom_col  <= '0;
      s1       <= PIPE_IDLE;
      s2       <= PIPE_IDLE;
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_data  <= '0;
    end else begin
      if (granted) begin
        rom_row <= req_row[int'(pick_idx)*ROW_W +: ROW_W];
        rom_col <= req_col[int'(pick_idx)*COL_W +: COL_W];
        s1      <= '{valid: 1'b1, id: ID_W_MAX'(pick_idx)};
      end else begin
        s1 <= PIPE_IDLE;
      end
      s2       <= s1;
      rd_valid <= s2.valid;
      if (s2.valid) begin
        rd_data <= rom_data;
        rd_id   <= s2.id[IW-1:0];
      end
    end
  end

`ifdef SPRITE_ARB_LOCK_EN
  localparam int LCW = $clog2(MAX_LOCK + 1);

  logic [LCW-1:0] lock_cnt;
  logic [LCW-1:0] cnt_next;
  logic [IW-1:0]  lock_id;

  // A grant continues the run only if the previous cycle granted the same locked requester.
  assign cnt_next = (lock_cnt != '0 && lock_id == pick_idx) ? lock_cnt + LCW'(1) : LCW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= '0;
      lock_cnt <= '0;
      lock_id  <= '0;
    end else if (granted) begin
      if (req_lock[pick_idx] && cnt_next != LCW'(MAX_LOCK)) begin
        ptr      <= pick_idx;
        lock_cnt <= cnt_next;
        lock_id  <= pick_idx;
      end else begin
        ptr      <= ptr_adv;
        lock_cnt <= '0;
      end
    end else begin
      lock_cnt <= '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock ^ (MAX_LOCK != 0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (granted) begin
      ptr <= ptr_adv;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: per-scenario tasks plus a read-data scoreboard.
module tb_sprite_rom_arbiter;

  localparam int NR = 4;
  localparam int RW = 5;
  localparam int CW = 5;
  localparam int DW = 12;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            arb_en = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR*RW-1:0] req_row = '0;
  logic [NR*CW-1:0] req_col = '0;
  logic [NR-1:0]   req_lock = '0;
  logic [NR-1:0]   gnt;
  logic [RW-1:0]   rom_row;
  logic [CW-1:0]   rom_col;
  logic [DW-1:0]   rom_data = '0;
  logic            rd_valid;
  logic [1:0]      rd_id;
  logic [DW-1:0]   rd_data;

  logic [15:0]     cyc = '0;
  logic [W-1:0]    exp_q[$];
  int              cmp_cnt = 0;
  int              err_cnt = 0;

  sprite_rom_arbiter #(.NUM_REQ(NR), .ROW_W(RW), .COL_W(CW), .DATA_W(DW), .MAX_LOCK(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .arb_en   (arb_en),
    .req      (req),
    .req_row  (req_row),
    .req_col  (req_col),
    .req_lock (req_lock),
    .gnt      (gnt),
    .rom_row  (rom_row),
    .rom_col  (rom_col),
    .rom_data (rom_data),
    .rd_valid (rd_valid),
    .rd_id    (rd_id),
    .rd_data  (rd_data)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  function automatic logic [DW-1:0] color_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return {c[1:0], r, c};
  endfunction

  // registered-address ROM model, one cycle read latency
  always @(posedge clk) rom_data <= color_of(rom_row, rom_col);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard: entries are {expected cycle, 1'b0, id[2:0], data[11:0]}
  always @(negedge clk) begin
    if (reset_n) begin
      while (exp_q.size() > 0 && exp_q[0][31:16] < cyc) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL sb_missing: no rd_valid at cycle %0d, required id=%0d data=%h",
                 exp_q[0][31:16], exp_q[0][14:12], exp_q[0][11:0]);
        void'(exp_q.pop_front());
      end
      if (rd_valid) begin
        cmp_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL sb_unexpected: rd_valid at cycle %0d id=%0d data=%h, required none",
                   cyc, rd_id, rd_data);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (e[31:16] !== cyc || {1'b0, rd_id} !== e[14:12] || rd_data !== e[11:0]) begin
            err_cnt++;
            $display("FAIL sb_read: got cycle=%0d id=%0d data=%h, required cycle=%0d id=%0d data=%h",
                     cyc, rd_id, rd_data, e[31:16], e[14:12], e[11:0]);
          end
        end
      end
    end
  end

  // driver tasks (entered and left at posedge+1)
  task automatic set_addr(input int i, input logic [RW-1:0] r, input logic [CW-1:0] c);
    req_row[i*RW +: RW] = r;
    req_col[i*CW +: CW] = c;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    req_lock = '0;
    arb_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic cycle_check(input logic [NR-1:0] exp_gnt, input string name);
    int idx;
    @(negedge clk);
    cmp_cnt++;
    if (gnt !== exp_gnt) begin
      err_cnt++;
      $display("FAIL %s: cycle %0d gnt=%b, required %b", name, cyc, gnt, exp_gnt);
    end
    if (exp_gnt != '0) begin
      idx = 0;
      for (int i = 0; i < NR; i++) if (exp_gnt[i]) idx = i;
      exp_q.push_back({cyc + 16'd3, 1'b0, 3'(idx),
                       color_of(req_row[idx*RW +: RW], req_col[idx*CW +: CW])});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    cmp_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: %0d reads outstanding after timeout, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    cmp_cnt++;
    if ({gnt, rom_row, rom_col, rd_valid, rd_id, rd_data} !== '0) begin
      err_cnt++;
      $display("FAIL reset_state: outputs=%h, required 0",
               {gnt, rom_row, rom_col, rd_valid, rd_id, rd_data});
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    do_reset();
    set_addr(2, 5'd3, 5'd7);
    req = 4'b0100;
    cycle_check(4'b0100, "single_gnt");
    req = '0;
    @(negedge clk);
    cmp_cnt++;
    if (rom_row !== 5'd3 || rom_col !== 5'd7) begin
      err_cnt++;
      $display("FAIL single_addr: rom_row=%0d rom_col=%0d, required 3/7", rom_row, rom_col);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NR; i++) set_addr(i, 5'(k), 5'(i * 5 + 1));
      cycle_check(4'(1 << (k % 4)), "rr_gnt");
    end
    req = '0;
    drain();
  endtask

  task automatic test_arb_en();
    logic [NR-1:0] exp_t [10];
    exp_t = '{4'h1, 4'h8, 4'h1, 4'h8, 4'h0, 4'h0, 4'h1, 4'h8, 4'h1, 4'h8};
    do_reset();
    req = 4'b1001;
    for (int k = 0; k < 10; k++) begin
      arb_en = !(k == 4 || k == 5);
      set_addr(0, 5'(k), 5'd2);
      set_addr(3, 5'(k + 10), 5'd9);
      cycle_check(exp_t[k], "arb_en_gnt");
    end
    req = '0;
    arb_en = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_addr(1, 5'd9, 5'd4);
    req = 4'b0010;
    @(negedge clk);
    cmp_cnt++;
    if (gnt !== 4'b0010) begin
      err_cnt++;
      $display("FAIL midrst_gnt: gnt=%b, required 0010", gnt);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    req = '0;
    #1;
    cmp_cnt++;
    if ({gnt, rom_row, rom_col, rd_valid, rd_id, rd_data} !== '0) begin
      err_cnt++;
      $display("FAIL midrst_outputs: outputs=%h, required 0",
               {gnt, rom_row, rom_col, rd_valid, rd_id, rd_data});
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cmp_cnt++;
      if (rd_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL midrst_rd_valid: rd_valid=%b at cycle %0d, required 0", rd_valid, cyc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lock();
    int n;
    logic [NR-1:0] e;
    do_reset();
    for (int i = 0; i < NR; i++) set_addr(i, 5'(i + 4), 5'(i + 8));
    req = 4'hF;
    req_lock = 4'b0010;
`ifdef SPRITE_ARB_LOCK_EN
    n = 18;
`else
    n = 5;
`endif
    for (int k = 0; k < n; k++) begin
`ifdef SPRITE_ARB_LOCK_EN
      if (k == 0) e = 4'b0001;
      else if (k <= 16) e = 4'b0010;
      else e = 4'b0100;
`else
      e = 4'(1 << (k % 4));
`endif
      cycle_check(e, "lock_gnt");
    end
    req = '0;
    req_lock = '0;
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_arb_en();
    test_reset_mid();
    test_lock();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
